// File: rtl/seg_scan_drv_pkg.sv
// Shared constants for the 7-segment display path: blanking codes, the hex glyph
// table and the leading-zero test used when SEG_SCAN_LZ_BLANK_EN is defined.
package seg_pkg;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [7:0] ANS_OFF    = 8'hFF;
  localparam int         MAX_DIGITS = 8;

  // Active-low glyphs, bit 6 = g ... bit 0 = a, indexed by nibble value.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // True when digit i (i >= 1) and every digit above it are zero.
  function automatic logic lz_blank(input logic [31:0] value, input logic [2:0] idx);
    return (idx != 3'd0) && ((value >> {idx, 2'b00}) == 32'd0);
  endfunction

endpackage

// File: rtl/seg_scan_drv_if.sv
// Load/acknowledge handshake plus the seg/ans board pins of the display driver.
interface seg_scan_drv_if;
  logic [31:0] data_in;
  logic        load;
  logic        upd_ack;
  logic        frame_tick;
  logic [6:0]  seg;
  logic [7:0]  ans;

  modport master (output data_in, load, input upd_ack, frame_tick, seg, ans);
  modport slave  (input data_in, load, output upd_ack, frame_tick, seg, ans);
endinterface

// File: rtl/seg_scan_drv_hex7seg.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = HEX_GLYPH[nib_i];
endmodule

// File: rtl/seg_scan_drv.sv
// Time-multiplexed 8-digit common-anode display driver with frame-aligned double
// buffering. Define SEG_SCAN_LZ_BLANK_EN to blank leading zero digits.
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DIGITS   = 8
) (
  input logic           clk,
  input logic           rst,
  seg_scan_drv_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shown_q, shown_d;
  logic [31:0]   pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          upd_ack_q, upd_ack_d;
  logic          frame_tick_q, frame_tick_d;
  logic [6:0]    seg_q, seg_d;
  logic [7:0]    ans_q, ans_d;

  logic       step, boundary, blank;
  logic [6:0] glyph;

  assign step     = (prescaler_q == PW'(SCAN_DIV - 1));
  assign boundary = step && (idx_q == 3'(DIGITS - 1));

  hex7seg u_hex7seg (
    .nib_i (shown_q[{idx_q, 2'b00} +: 4]),
    .seg_o (glyph)
  );

`ifdef SEG_SCAN_LZ_BLANK_EN
  assign blank = lz_blank(shown_q, idx_q);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    prescaler_d  = step ? '0 : prescaler_q + 1'b1;
    idx_d        = idx_q;
    shown_d      = shown_q;
    pend_d       = pend_q;
    pend_v_d     = pend_v_q;
    upd_ack_d    = 1'b0;
    frame_tick_d = boundary;

    if (step) idx_d = boundary ? 3'd0 : idx_q + 1'b1;

    // A load landing on the boundary bypasses the pending buffer entirely.
    if (boundary) begin
      if (bus.load) begin
        shown_d   = bus.data_in;
        upd_ack_d = 1'b1;
      end else if (pend_v_q) begin
        shown_d   = pend_q;
        upd_ack_d = 1'b1;
      end
      pend_v_d = 1'b0;
    end else if (bus.load) begin
      pend_d   = bus.data_in;
      pend_v_d = 1'b1;
    end
  end

  always_comb begin
    seg_d = SEG_OFF;
    ans_d = ANS_OFF;
    if (!blank) begin
      seg_d        = glyph;
      ans_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      prescaler_q  <= '0;
      idx_q        <= '0;
      shown_q      <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      upd_ack_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_q        <= SEG_OFF;
      ans_q        <= ANS_OFF;
    end else begin
      prescaler_q  <= prescaler_d;
      idx_q        <= idx_d;
      shown_q      <= shown_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      upd_ack_q    <= upd_ack_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      ans_q        <= ans_d;
    end
  end

  assign bus.upd_ack    = upd_ack_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.seg        = seg_q;
  assign bus.ans        = ans_q;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Directed bench for seg_scan_drv with SCAN_DIV=4, DIGITS=8; expectations follow
// SEG_SCAN_LZ_BLANK_EN when it is defined.
module tb_seg_scan_drv;

`ifdef SEG_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   n = 0;
  int   ack_cnt = 0;
  int   d;
  logic [7:0] one8 = 8'h01;
  logic [7:0] exp_ans;
  logic [6:0] exp_seg;

  seg_scan_drv_if bus();

  seg_scan_drv #(.SCAN_DIV(4), .DIGITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    if (bus.upd_ack === 1'b1) ack_cnt++;
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  task automatic pulse_load(input logic [31:0] value);
    bus.data_in = value;
    bus.load    = 1'b1;
    tick();
    bus.load    = 1'b0;
  endtask

  initial begin
    bus.data_in = '0;
    bus.load    = 1'b0;

    // 1. reset and startup scan
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", bus.seg, 7'h7F);
    check("rst_ans", bus.ans, 8'hFF);
    check("rst_ack", bus.upd_ack, 1'b0);
    check("rst_ft",  bus.frame_tick, 1'b0);
    rst = 1'b0;
    n = 0;
    tick();
    check("start_ans0", bus.ans, 8'hFE);
    check("start_seg0", bus.seg, 7'h40);
    run_to(4);
    check("start_ans0_hold", bus.ans, 8'hFE);
    run_to(5);
    check("start_ans1", bus.ans, LZ ? 8'hFF : 8'hFD);
    check("start_seg1", bus.seg, LZ ? 7'h7F : 7'h40);

    // 2. basic load mid-frame
    run_to(10);
    ack_cnt = 0;
    pulse_load(32'h12345678);
    run_to(31);
    check("basic_no_early_ack", ack_cnt, 0);
    run_to(32);
    check("basic_ack", bus.upd_ack, 1'b1);
    check("basic_ft", bus.frame_tick, 1'b1);
    run_to(33);
    check("basic_d0_ans", bus.ans, 8'hFE);
    check("basic_d0_seg", bus.seg, 7'h00);
    run_to(45);
    check("basic_d3_ans", bus.ans, 8'hF7);
    check("basic_d3_seg", bus.seg, 7'h12);
    run_to(61);
    check("basic_d7_ans", bus.ans, 8'h7F);
    check("basic_d7_seg", bus.seg, 7'h79);
    run_to(64);
    check("basic_ft2", bus.frame_tick, 1'b1);
    check("basic_no_ack2", bus.upd_ack, 1'b0);
    check("basic_ack_once", ack_cnt, 1);

    // 3. back-to-back loads within one frame: last one wins
    ack_cnt = 0;
    run_to(65);
    pulse_load(32'hAAAAAAAA);
    run_to(69);
    pulse_load(32'h0000000F);
    run_to(96);
    check("b2b_ack", bus.upd_ack, 1'b1);
    run_to(97);
    check("b2b_d0_ans", bus.ans, 8'hFE);
    check("b2b_d0_seg", bus.seg, 7'h0E);
    run_to(101);
    check("b2b_d1_ans", bus.ans, LZ ? 8'hFF : 8'hFD);
    check("b2b_d1_seg", bus.seg, LZ ? 7'h7F : 7'h40);
    run_to(125);
    check("b2b_d7_ans", bus.ans, LZ ? 8'hFF : 8'h7F);
    check("b2b_d7_seg", bus.seg, LZ ? 7'h7F : 7'h40);
    check("b2b_ack_once", ack_cnt, 1);

    // 4. load in the boundary cycle itself
    ack_cnt = 0;
    run_to(127);
    pulse_load(32'hFFFFFFFF);
    check("bnd_ack", bus.upd_ack, 1'b1);
    check("bnd_ft", bus.frame_tick, 1'b1);
    run_to(160);
    check("bnd_ft2", bus.frame_tick, 1'b1);
    check("bnd_no_ack2", bus.upd_ack, 1'b0);
    check("bnd_ack_once", ack_cnt, 1);
    run_to(161);
    check("bnd_d0_seg", bus.seg, 7'h0E);

    // 5. reset mid-frame drops the pending load
    run_to(170);
    pulse_load(32'h87654321);
    run_to(175);
    rst = 1'b1;
    #1;
    check("mid_rst_seg", bus.seg, 7'h7F);
    check("mid_rst_ans", bus.ans, 8'hFF);
    check("mid_rst_ack", bus.upd_ack, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    ack_cnt = 0;
    tick();
    check("post_rst_ans0", bus.ans, 8'hFE);
    check("post_rst_seg0", bus.seg, 7'h40);
    run_to(37);
    check("post_rst_d1_ans", bus.ans, LZ ? 8'hFF : 8'hFD);
    check("post_rst_d1_seg", bus.seg, LZ ? 7'h7F : 7'h40);
    run_to(40);
    check("post_rst_no_ack", ack_cnt, 0);

    // 6. leading-zero behaviour: 0x42 then 0x0, checked every cycle of a frame
    run_to(40);
    pulse_load(32'h00000042);
    run_to(64);
    check("lz42_ack", bus.upd_ack, 1'b1);
    for (int c = 65; c <= 96; c++) begin
      run_to(c);
      d = ((c - 1) / 4) % 8;
      exp_ans = (LZ && d >= 2) ? 8'hFF : ~(one8 << d);
      exp_seg = (d == 0) ? 7'h24 : (d == 1) ? 7'h19 : (LZ ? 7'h7F : 7'h40);
      check($sformatf("lz42_ans_c%0d", c), bus.ans, exp_ans);
      check($sformatf("lz42_seg_c%0d", c), bus.seg, exp_seg);
    end
    pulse_load(32'h00000000);
    run_to(128);
    check("lz0_ack", bus.upd_ack, 1'b1);
    for (int c = 129; c <= 160; c++) begin
      run_to(c);
      d = ((c - 1) / 4) % 8;
      exp_ans = (LZ && d >= 1) ? 8'hFF : ~(one8 << d);
      exp_seg = (LZ && d >= 1) ? 7'h7F : 7'h40;
      check($sformatf("lz0_ans_c%0d", c), bus.ans, exp_ans);
      check($sformatf("lz0_seg_c%0d", c), bus.seg, exp_seg);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_drv.md
Name: seg_scan_drv

Overview:
- Downstream display stage for the ALU top level.
- Accepts a 32-bit result word (8 hex nibbles) and time-multiplexes it onto an 8-digit common-anode 7-segment display.
- Drives the seg[6:0] / ans[7:0] board pins.
- The displayed value is double-buffered and swapped only at frame boundaries, so the display never tears.

Parameters:
- SCAN_DIV, 100000: clk cycles each digit stays lit; legal range ≥2.
- DIGITS, 8: number of active digits, 1..8. ans bits at index ≥DIGITS are tied 1 (off).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- data_in  in  32  value to display; nibble i shown on digit i
- load  in  1  1-cycle strobe; captures data_in
- upd_ack  out  1  1-cycle pulse when a loaded value becomes the displayed value
- frame_tick  out  1  1-cycle pulse at each frame wrap (digit DIGITS-1 → 0)
- seg  out  7  segments, active low; seg[6]=g … seg[0]=a
- ans  out  8  digit enables, active low; ans[i]=0 lights digit i

Behaviour:
- Reset (async assert, sync release):
  - Internal state: prescaler=0, idx=0, shown=0, pend=0, pend_v=0.
  - Outputs: upd_ack=0, frame_tick=0, seg=7'h7F, ans=8'hFF.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - On the wrap cycle ("step"), idx advances by 1.
  - When idx=DIGITS-1 at a step, idx wraps to 0. That cycle is the "boundary".
- frame_tick is registered and asserts the cycle after each boundary.
- Load handling:
  - load outside a boundary: pend←data_in, pend_v←1. Last load wins; earlier pending data is discarded.
  - Boundary with pend_v=1 and no load: shown←pend, pend_v←0, upd_ack=1 next cycle.
  - Load coincident with a boundary: shown←data_in directly, pend_v←0, upd_ack=1 next cycle. Any older pend is dropped.
  - Boundary with pend_v=0 and no load: shown holds; no upd_ack.
- Output pipeline:
  - seg and ans are registered from (idx, shown), so they follow an idx change with 1-cycle latency.
  - ans: exactly one of ans[DIGITS-1:0] is low at a time (unless blanked); upper bits are always 1.
  - seg decodes shown[4*idx+3:4*idx] to hex glyphs 0-F, active low. Required codes:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Reset mid-operation: all state clears immediately; pending data is lost and no upd_ack is issued.
- Timing:
  - Digit period = SCAN_DIV cycles.
  - Frame = SCAN_DIV*DIGITS cycles.
  - Worst-case load-to-display latency = one frame + 2 cycles.

Optional Feature:
- Macro: SEG_SCAN_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Digit i (i≥1) is blanked when every nibble of shown at index ≥i is 0.
  - Blanked means ans[i]=1 and seg=7'h7F during its slot.
  - Digit 0 is never blanked. Scan timing is unchanged.
- Undefined: all DIGITS digits are always shown, including zeros.

Decomposition:
- Package seg_pkg contains:
  - SEG_OFF=7'h7F
  - ANS_OFF=8'hFF
  - MAX_DIGITS=8
  - the 16-entry hex glyph constant table
- One combinational sub-module, hex7seg (4-bit nibble → 7-bit active-low seg), reusable by other display paths.
- seg_scan_drv contains the prescaler, digit counter, buffer logic and output registers.

Test Plan:
All scenarios use SCAN_DIV=4, DIGITS=8.
1. Reset / startup: assert rst → seg=7F, ans=FF. First registered cycle after release → ans=FE, seg=1000000. ans=FD four cycles later.
2. Basic load: load 32'h12345678 mid-frame → upd_ack exactly once, one cycle after the next boundary. In the following frame: ans=FE shows 0000000 ('8'); ans=F7 shows 0010010 ('5'); ans=7F shows 1111001 ('1').
3. Back-to-back loads: load 32'hAAAAAAAA then 32'h0000000F within one frame → single upd_ack; digit 0 shows 0001110 ('F'), digits 1-7 show 1000000.
4. Load on boundary: pulse load with 32'hFFFFFFFF in the boundary cycle → upd_ack next cycle. frame_tick and upd_ack coincide; no second ack at the following boundary.
5. Reset mid-frame: load, then assert rst before the boundary → outputs at reset values; after release shown=0 and no upd_ack ever fires for that load.
6. Blanking (macro defined): load 32'h00000042 → only ans[0] and ans[1] ever go low; digit 1 shows 0011001 ('4'). With 32'h0 loaded, only digit 0 lights, showing 1000000.
